// File: rtl/keypad_scanner_if.sv
// keypad_scanner_if: keypad pins and decoded-key strobes shared between the
// keypad scanner (master) and the calculator controller side (slave).
interface keypad_scanner_if;
    logic [3:0] row_in;
    logic [3:0] col_out;
    logic       digit_valid;
    logic [3:0] digit;
    logic       op_valid;
    logic [1:0] op_code;
    logic       equal_valid;
    logic       clear_valid;
    logic       busy;

    modport master (
        input  row_in,
        output col_out, digit_valid, digit, op_valid, op_code,
               equal_valid, clear_valid, busy
    );

    modport slave (
        output row_in,
        input  col_out, digit_valid, digit, op_valid, op_code,
               equal_valid, clear_valid, busy
    );
endinterface

// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 active-low matrix keypad, synchronises and
// debounces the rows, and emits one single-cycle strobe per accepted press.
// Optional feature: define KEYPAD_REPEAT_EN to add digit auto-repeat while a
// digit key stays held (REPEAT_DELAY / REPEAT_PERIOD only matter then).
module keypad_scanner #(
    parameter int SCAN_DIV        = 16,
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int REPEAT_DELAY    = 500000,
    parameter int REPEAT_PERIOD   = 100000
) (
    input  logic             clk,
    input  logic             reset,
    keypad_scanner_if.master kp
);
    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DEB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(SCAN_DIV - 1);
    localparam logic [DEB_W-1:0] DEB_MAX = DEB_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_SCAN        = 3'd0,
        ST_DEB_PRESS   = 3'd1,
        ST_EMIT        = 3'd2,
        ST_HOLD        = 3'd3,
        ST_DEB_RELEASE = 3'd4
    } state_t;

    // True when exactly one line of an active-low nibble is low.
    function automatic logic one_low(input logic [3:0] p);
        logic res_s;
        case (p)
            4'b1110, 4'b1101, 4'b1011, 4'b0111: res_s = 1'b1;
            default:                            res_s = 1'b0;
        endcase
        return res_s;
    endfunction

    // Index of the low line in a one-low nibble (0 for anything else).
    function automatic logic [1:0] low_index(input logic [3:0] p);
        logic [1:0] idx_s;
        case (p)
            4'b1101: idx_s = 2'd1;
            4'b1011: idx_s = 2'd2;
            4'b0111: idx_s = 2'd3;
            default: idx_s = 2'd0;
        endcase
        return idx_s;
    endfunction

    logic [3:0]       rs_meta_q, rs_q;
    state_t           state_q, state_d;
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
    logic [3:0]       pat_q, pat_d;
    logic [3:0]       col_q, col_d;
    logic             digit_valid_q, digit_valid_d;
    logic [3:0]       digit_q, digit_d;
    logic             op_valid_q, op_valid_d;
    logic [1:0]       op_code_q, op_code_d;
    logic             equal_valid_q, equal_valid_d;
    logic             clear_valid_q, clear_valid_d;
    logic             busy_q, busy_d;
    logic [1:0]       row_s, col_idx_s;
`ifdef KEYPAD_REPEAT_EN
    logic [31:0]      rpt_cnt_q, rpt_cnt_d;
    logic             rpt_first_q, rpt_first_d;
    logic             key_is_digit_s;
`endif

    // Two-flop synchroniser for the asynchronous keypad rows.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rs_meta_q <= 4'hF;
            rs_q      <= 4'hF;
        end else begin
            rs_meta_q <= kp.row_in;
            rs_q      <= rs_meta_q;
        end
    end

    // Next-state and output decode; strobes are computed one cycle ahead so
    // the registered strobe lines up with the EMIT state.
    always_comb begin
        state_d       = state_q;
        div_cnt_d     = div_cnt_q;
        deb_cnt_d     = deb_cnt_q;
        pat_d         = pat_q;
        col_d         = col_q;
        digit_valid_d = 1'b0;
        digit_d       = digit_q;
        op_valid_d    = 1'b0;
        op_code_d     = op_code_q;
        equal_valid_d = 1'b0;
        clear_valid_d = 1'b0;
        row_s         = low_index(pat_q);
        col_idx_s     = low_index(col_q);
        case (state_q)
            ST_SCAN: begin
                if (div_cnt_q == DIV_MAX) begin
                    div_cnt_d = '0;
                    if (one_low(rs_q)) begin
                        // column stays driven while the press is debounced
                        state_d   = ST_DEB_PRESS;
                        pat_d     = rs_q;
                        deb_cnt_d = '0;
                    end else begin
                        col_d = {col_q[2:0], col_q[3]};
                    end
                end else begin
                    div_cnt_d = div_cnt_q + {{(DIV_W-1){1'b0}}, 1'b1};
                end
            end
            ST_DEB_PRESS: begin
                if (rs_q != pat_q) begin
                    state_d   = ST_SCAN;
                    div_cnt_d = '0;
                    col_d     = {col_q[2:0], col_q[3]};
                end else if (deb_cnt_q == DEB_MAX) begin
                    state_d = ST_EMIT;
                    if (col_idx_s == 2'd3) begin
                        op_valid_d = 1'b1;
                        op_code_d  = row_s;
                    end else if ((row_s == 2'd3) && (col_idx_s == 2'd0)) begin
                        clear_valid_d = 1'b1;
                    end else if ((row_s == 2'd3) && (col_idx_s == 2'd2)) begin
                        equal_valid_d = 1'b1;
                    end else begin
                        digit_valid_d = 1'b1;
                        digit_d = (row_s == 2'd3) ? 4'd0 :
                                  ({2'b00, row_s} * 4'd3 + {2'b00, col_idx_s} + 4'd1);
                    end
                end else begin
                    deb_cnt_d = deb_cnt_q + {{(DEB_W-1){1'b0}}, 1'b1};
                end
            end
            ST_EMIT: begin
                state_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (rs_q == 4'hF) begin
                    state_d   = ST_DEB_RELEASE;
                    deb_cnt_d = '0;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            ST_DEB_RELEASE: begin
                if (rs_q != 4'hF) begin
                    state_d = ST_HOLD;
                end else if (deb_cnt_q == DEB_MAX) begin
                    state_d   = ST_SCAN;
                    div_cnt_d = '0;
                    col_d     = {col_q[2:0], col_q[3]};
                end else begin
                    deb_cnt_d = deb_cnt_q + {{(DEB_W-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_d   = ST_SCAN;
                div_cnt_d = '0;
                col_d     = 4'b1110;
            end
        endcase
`ifdef KEYPAD_REPEAT_EN
        // rpt_cnt tracks cycles since EMIT (then since the last repeat);
        // any excursion out of HOLD restarts it.
        key_is_digit_s = (col_idx_s != 2'd3) && !((row_s == 2'd3) && (col_idx_s != 2'd1));
        rpt_cnt_d      = 32'd0;
        rpt_first_d    = 1'b1;
        if (state_q == ST_EMIT) begin
            rpt_cnt_d = 32'd1;
        end else if ((state_q == ST_HOLD) && (rs_q != 4'hF) && key_is_digit_s) begin
            if ((rpt_cnt_q + 32'd1) == (rpt_first_q ? 32'(REPEAT_DELAY) : 32'(REPEAT_PERIOD))) begin
                digit_valid_d = 1'b1;
                rpt_cnt_d     = 32'd0;
                rpt_first_d   = 1'b0;
            end else begin
                rpt_cnt_d   = rpt_cnt_q + 32'd1;
                rpt_first_d = rpt_first_q;
            end
        end else begin
            rpt_cnt_d = 32'd0;
        end
`endif
        busy_d = (state_d != ST_SCAN);
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_SCAN;
            div_cnt_q     <= '0;
            deb_cnt_q     <= '0;
            pat_q         <= 4'hF;
            col_q         <= 4'b1110;
            digit_valid_q <= 1'b0;
            digit_q       <= 4'd0;
            op_valid_q    <= 1'b0;
            op_code_q     <= 2'd0;
            equal_valid_q <= 1'b0;
            clear_valid_q <= 1'b0;
            busy_q        <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            rpt_cnt_q     <= 32'd0;
            rpt_first_q   <= 1'b1;
`endif
        end else begin
            state_q       <= state_d;
            div_cnt_q     <= div_cnt_d;
            deb_cnt_q     <= deb_cnt_d;
            pat_q         <= pat_d;
            col_q         <= col_d;
            digit_valid_q <= digit_valid_d;
            digit_q       <= digit_d;
            op_valid_q    <= op_valid_d;
            op_code_q     <= op_code_d;
            equal_valid_q <= equal_valid_d;
            clear_valid_q <= clear_valid_d;
            busy_q        <= busy_d;
`ifdef KEYPAD_REPEAT_EN
            rpt_cnt_q     <= rpt_cnt_d;
            rpt_first_q   <= rpt_first_d;
`endif
        end
    end

    assign kp.col_out     = col_q;
    assign kp.digit_valid = digit_valid_q;
    assign kp.digit       = digit_q;
    assign kp.op_valid    = op_valid_q;
    assign kp.op_code     = op_code_q;
    assign kp.equal_valid = equal_valid_q;
    assign kp.clear_valid = clear_valid_q;
    assign kp.busy        = busy_q;
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: models a physical 4x4 keypad, drives directed and random
// press patterns, and checks every strobe against a key-map based event model.
`timescale 1ns/1ps
module tb_keypad_scanner;
    localparam int SD  = 4;
    localparam int DB  = 8;
    localparam int RD  = 40;
    localparam int RP  = 10;
    localparam int LAT = 2 + 4*SD + DB + 1;

    typedef struct {
        int kind;      // 0 digit, 1 op, 2 equal, 3 clear
        int val;
        int deadline;
    } ev_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] key_down = 16'h0000;   // index = row*4 + col
    logic [3:0]  row_v;
    int          cyc = 0;
    int          vectors = 0;
    int          miscompares = 0;
    int          model_digit = 0;
    int          model_op = 0;
    ev_t         exp_q[$];
    int          dig_times[$];

    keypad_scanner_if kif();

    keypad_scanner #(
        .SCAN_DIV(SD), .DEBOUNCE_CYCLES(DB),
        .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
    ) dut (
        .clk(clk), .reset(reset), .kp(kif)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Physical matrix: a row is pulled low when a pressed key sits on a driven column.
    always_comb begin
        for (int r = 0; r < 4; r++) begin
            row_v[r] = 1'b1;
            for (int c = 0; c < 4; c++)
                if (key_down[r*4+c] && !kif.col_out[c]) row_v[r] = 1'b0;
        end
    end
    assign kif.row_in = row_v;

    function automatic void check(input bit ok, input string name, input int act, input int req);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endfunction

    // Keypad legend -> event kind/value.
    function automatic void key_expect(input int k, output int kind, output int val);
        string m;
        byte   ch;
        m  = "123A456B789C*0#D";
        ch = m[k];
        if (ch >= "0" && ch <= "9")      begin kind = 0; val = ch - "0"; end
        else if (ch >= "A" && ch <= "D") begin kind = 1; val = ch - "A"; end
        else if (ch == "#")              begin kind = 2; val = 0; end
        else                             begin kind = 3; val = 0; end
    endfunction

    function automatic void push_ev(input int k, input int deadline);
        ev_t e;
        key_expect(k, e.kind, e.val);
        e.deadline = deadline;
        exp_q.push_back(e);
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic press(input int k, input int hold, input bit expect_ev, input int gap);
        key_down[k] = 1'b1;
        if (expect_ev) push_ev(k, cyc + LAT);
        tick(hold);
        key_down[k] = 1'b0;
        tick(gap);
    endtask

    // Per-cycle compare of strobes and held outputs against the event model.
    always @(negedge clk) begin : cmp
        int n;
        int kind;
        ev_t e;
        if (!reset) begin
            n = int'(kif.digit_valid) + int'(kif.op_valid) + int'(kif.equal_valid) + int'(kif.clear_valid);
            check(n <= 1, "strobe_exclusive", n, 1);
            check($countones(~kif.col_out) == 1, "col_one_hot_low", int'(kif.col_out), 0);
            if (exp_q.size() > 0 && exp_q[0].deadline < cyc) begin
                check(1'b0, "strobe_timeout", cyc, exp_q[0].deadline);
                void'(exp_q.pop_front());
            end
            if (n == 1) begin
                kind = kif.digit_valid ? 0 : kif.op_valid ? 1 : kif.equal_valid ? 2 : 3;
                if (kind == 0) dig_times.push_back(cyc);
                if (exp_q.size() == 0) begin
                    check(1'b0, "unexpected_strobe", kind, -1);
                end else begin
                    e = exp_q.pop_front();
                    check(kind == e.kind, "strobe_kind", kind, e.kind);
                    if (e.kind == 0) model_digit = e.val;
                    if (e.kind == 1) model_op = e.val;
                end
            end
            check(int'(kif.digit) == model_digit, "digit_value", int'(kif.digit), model_digit);
            check(int'(kif.op_code) == model_op, "op_code_value", int'(kif.op_code), model_op);
        end
    end

    initial begin : stim
        logic [3:0] rot [4];
        logic [3:0] hist [$];
        int i0, p, t0, waited, k, r1, r2, c, mode;
        rot[0] = 4'b1110; rot[1] = 4'b1101; rot[2] = 4'b1011; rot[3] = 4'b0111;

        // reset, then idle scanning
        reset = 1'b1;
        tick(3);
        reset = 1'b0;
        for (int i = 0; i < 34; i++) begin
            @(negedge clk);
            hist.push_back(kif.col_out);
            if (kif.busy) check(1'b0, "idle_busy", 1, 0);
        end
        check(hist[0] == 4'b1110, "reset_col", int'(hist[0]), 14);
        i0 = 0;
        for (int i = 1; i < hist.size(); i++)
            if (i0 == 0 && hist[i] != hist[0]) i0 = i;
        check(i0 >= 1 && i0 <= SD, "first_rotate", i0, SD);
        for (int j = i0; j < hist.size(); j++)
            check(hist[j] == rot[(1 + (j - i0) / SD) % 4], "col_rotation", int'(hist[j]),
                  int'(rot[(1 + (j - i0) / SD) % 4]));
        tick(1);

        // clean '7' with latency bound
        dig_times.delete();
        p = cyc;
        press(8, 45, 1'b1, 20);
        check(dig_times.size() == 1, "seven_count", dig_times.size(), 1);
        if (dig_times.size() > 0) check(dig_times[0] - p <= LAT, "seven_latency", dig_times[0] - p, LAT);
        check(int'(kif.digit) == 7, "seven_digit", int'(kif.digit), 7);

        // bouncy 'B', then a too-short press
        key_down[7] = 1'b1; tick(1);
        key_down[7] = 1'b0; tick(1);
        press(7, 45, 1'b1, 20);
        check(int'(kif.op_code) == 1, "b_op_code", int'(kif.op_code), 1);
        press(7, 5, 1'b0, 20);

        // sequence 1 2 A 3 # *
        press(0, 40, 1'b1, 20);
        press(1, 40, 1'b1, 20);
        press(3, 40, 1'b1, 20);
        press(2, 40, 1'b1, 20);
        press(14, 40, 1'b1, 20);
        press(12, 40, 1'b1, 20);
        check(int'(kif.digit) == 3, "seq_digit_held", int'(kif.digit), 3);
        check(int'(kif.op_code) == 0, "seq_op_held", int'(kif.op_code), 0);

        // chord 5+8 from idle, then 8 added to a held 5
        key_down[5] = 1'b1; key_down[9] = 1'b1;
        tick(45);
        key_down = 16'h0000;
        tick(20);
        key_down[5] = 1'b1;
        push_ev(5, cyc + LAT);
        tick(28);
        key_down[9] = 1'b1;
        tick(12);
        key_down = 16'h0000;
        tick(20);
        check(int'(kif.digit) == 5, "chord_digit", int'(kif.digit), 5);

        // reset in DEB_PRESS
        key_down[10] = 1'b1;
        waited = 0;
        while (!kif.busy && waited < LAT) begin tick(1); waited++; end
        check(kif.busy == 1'b1, "reach_deb_press", int'(kif.busy), 1);
        reset = 1'b1;
        key_down = 16'h0000;
        model_digit = 0;
        model_op = 0;
        @(negedge clk);
        check(kif.col_out == 4'b1110, "rst_col", int'(kif.col_out), 14);
        check(int'(kif.digit) == 0, "rst_digit", int'(kif.digit), 0);
        check(kif.busy == 1'b0, "rst_busy", int'(kif.busy), 0);
        check({kif.digit_valid, kif.op_valid, kif.equal_valid, kif.clear_valid} == 4'b0000,
              "rst_strobes", int'({kif.digit_valid, kif.op_valid, kif.equal_valid, kif.clear_valid}), 0);
        tick(2);
        reset = 1'b0;
        tick(20);

        // long hold of '4': auto-repeat only when the feature is built in
        dig_times.delete();
        p = cyc;
        key_down[4] = 1'b1;
        push_ev(4, p + LAT);
`ifdef KEYPAD_REPEAT_EN
        for (int i = 0; i < 4; i++) push_ev(4, p + LAT + 200);
`endif
        waited = 0;
        while (dig_times.size() == 0 && waited < LAT + 2) begin tick(1); waited++; end
        if (dig_times.size() > 0) begin
            t0 = dig_times[0];
            tick(t0 + 75 - cyc);
        end else begin
            tick(75);
        end
        key_down[4] = 1'b0;
        tick(30);
`ifdef KEYPAD_REPEAT_EN
        check(dig_times.size() == 5, "repeat_count", dig_times.size(), 5);
        for (int i = 1; i < 5; i++)
            if (i < dig_times.size())
                check(dig_times[i] - dig_times[0] == 30 + 10*i, "repeat_offset",
                      dig_times[i] - dig_times[0], 30 + 10*i);
`else
        check(dig_times.size() == 1, "no_repeat_count", dig_times.size(), 1);
`endif
        press(14, 80, 1'b1, 30);

        // random presses, short taps and same-column chords
        for (int it = 0; it < 30; it++) begin
            mode = int'($urandom_range(0, 9));
            if (mode <= 6) begin
                k = int'($urandom_range(0, 15));
                press(k, int'($urandom_range(30, 45)), 1'b1, int'($urandom_range(15, 30)));
            end else if (mode == 7) begin
                k = int'($urandom_range(0, 15));
                press(k, int'($urandom_range(2, 5)), 1'b0, int'($urandom_range(15, 30)));
            end else begin
                c  = int'($urandom_range(0, 3));
                r1 = int'($urandom_range(0, 3));
                r2 = (r1 + int'($urandom_range(1, 3))) % 4;
                key_down[r1*4+c] = 1'b1;
                key_down[r2*4+c] = 1'b1;
                tick(int'($urandom_range(30, 45)));
                key_down = 16'h0000;
                tick(int'($urandom_range(15, 30)));
            end
            if (kif.busy) check(1'b0, "idle_after_release", 1, 0);
        end

        tick(LAT + 5);
        check(exp_q.size() == 0, "pending_events", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
